spi_frame_collector: RTL and testbench

Parametrised RTL SPI frame collector for the SPI master IP verification environment. It passively watches the master's sck/csn/mosi pins, splits each chip-select frame into command, address, dummy and data fields using per-frame programmed lengths, and hands one assembled packet per frame to the scoreboard side over a valid/ready handshake. It generalises the fixed-width collector packet: field widths, length widths and chip-select count are parameters, and it adds frame-integrity flags and overflow detection.

---
 rtl/spi_frame_collector_if.sv | 44 ++++
 rtl/spi_frame_collector.sv | 237 +++++++++++++++++++++++
 tb/tb_spi_frame_collector.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/spi_frame_collector_if.sv
// Packet-side bundle of spi_frame_collector: one assembled SPI frame per transfer.
// Optional read-data field is present when SPI_COLLECTOR_MISO_EN is defined.
interface spi_frame_collector_if #(
   parameter int CMD_W   = 32,
   parameter int ADDR_W  = 32,
   parameter int DUMMY_W = 16,
   parameter int DATA_W  = 32,
   parameter int NUM_CS  = 4
);
   localparam int CS_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

   // Handshake: a packet transfers on every clk edge where pkt_valid_o && pkt_ready_i;
   // once raised, pkt_valid_o and all packet fields hold steady until that edge.
   logic               pkt_valid_o;
   logic               pkt_ready_i;
   logic [CMD_W-1:0]   pkt_cmd_o;
   logic [ADDR_W-1:0]  pkt_addr_o;
   logic [DUMMY_W-1:0] pkt_dummy_o;
   logic [DATA_W-1:0]  pkt_data_o;
   logic [CS_W-1:0]    pkt_cs_o;
   logic [15:0]        pkt_bits_o;
   logic [2:0]         pkt_flag_o;
`ifdef SPI_COLLECTOR_MISO_EN
   logic [DATA_W-1:0]  pkt_rdata_o;
`endif

   modport master (
`ifdef SPI_COLLECTOR_MISO_EN
      output pkt_rdata_o,
`endif
      output pkt_valid_o, pkt_cmd_o, pkt_addr_o, pkt_dummy_o, pkt_data_o,
      output pkt_cs_o, pkt_bits_o, pkt_flag_o,
      input  pkt_ready_i
   );

   modport slave (
`ifdef SPI_COLLECTOR_MISO_EN
      input  pkt_rdata_o,
`endif
      input  pkt_valid_o, pkt_cmd_o, pkt_addr_o, pkt_dummy_o, pkt_data_o,
      input  pkt_cs_o, pkt_bits_o, pkt_flag_o,
      output pkt_ready_i
   );
endinterface

// File: rtl/spi_frame_collector.sv
// Passive SPI frame collector: splits each chip-select frame into cmd/addr/dummy/data fields.
// Optional MISO capture into pkt_rdata_o is enabled by defining SPI_COLLECTOR_MISO_EN.
module spi_frame_collector #(
   parameter int CMD_W   = 32,
   parameter int ADDR_W  = 32,
   parameter int DUMMY_W = 16,
   parameter int DATA_W  = 32,
   parameter int LEN_W   = 6,
   parameter int NUM_CS  = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [LEN_W-1:0]  cmd_len_i,
   input  logic [LEN_W-1:0]  addr_len_i,
   input  logic [LEN_W-1:0]  dummy_len_i,
   input  logic [LEN_W-1:0]  data_len_i,
   input  logic              spi_sck_i,
   input  logic [NUM_CS-1:0] spi_csn_i,
   input  logic              spi_mosi_i,
`ifdef SPI_COLLECTOR_MISO_EN
   input  logic              spi_miso_i,
`endif
   spi_frame_collector_if.master pkt,
   output logic              ovf_o,
   output logic [2:0]        dbg_state_o
);
   localparam int CS_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_TAIL
   } state_t;

   state_t state;

   logic [1:0]        sck_sync;
   logic              sck_d;
   logic [NUM_CS-1:0] csn_sync1, csn_s, csn_d;
   logic [1:0]        mosi_sync;
   logic              armed;
   logic [1:0]        settle;
   logic [CS_W-1:0]   cs_sel;
   logic [LEN_W-1:0]  cmd_len_q, addr_len_q, dummy_len_q, data_len_q;
   logic [LEN_W-1:0]  ctr;
   logic [15:0]       bit_cnt;
   logic              excess;
   logic [CMD_W-1:0]   cmd_sr;
   logic [ADDR_W-1:0]  addr_sr;
   logic [DUMMY_W-1:0] dummy_sr;
   logic [DATA_W-1:0]  data_sr;
`ifdef SPI_COLLECTOR_MISO_EN
   logic [1:0]         miso_sync;
   logic [DATA_W-1:0]  rdata_sr;
`endif

   function automatic logic [LEN_W-1:0] sat_len(input logic [LEN_W-1:0] len, input int w);
      if (int'(len) > w) return LEN_W'(w);
      return len;
   endfunction

   // Next phase after 'from' whose length is nonzero; TAIL once nothing remains.
   function automatic state_t next_phase(input state_t from, input logic c, input logic a,
                                         input logic d, input logic t);
      state_t r;
      r = S_TAIL;
      if (from == S_IDLE && c) r = S_CMD;
      else if ((from == S_IDLE || from == S_CMD) && a) r = S_ADDR;
      else if ((from == S_IDLE || from == S_CMD || from == S_ADDR) && d) r = S_DUMMY;
      else if (from != S_DATA && from != S_TAIL && t) r = S_DATA;
      return r;
   endfunction

   logic [LEN_W-1:0] cmd_sat, addr_sat, dummy_sat, data_sat;
   logic [LEN_W-1:0] phase_len, ctr_inc;
   logic [CS_W-1:0]  first_low;
   logic             sck_rise, csn_fall_any, sel_rise;

   assign cmd_sat      = sat_len(cmd_len_i, CMD_W);
   assign addr_sat     = sat_len(addr_len_i, ADDR_W);
   assign dummy_sat    = sat_len(dummy_len_i, DUMMY_W);
   assign data_sat     = sat_len(data_len_i, DATA_W);
   assign sck_rise     = sck_sync[1] & ~sck_d;
   assign csn_fall_any = |(csn_d & ~csn_s);
   assign sel_rise     = csn_s[cs_sel] & ~csn_d[cs_sel];
   assign ctr_inc      = ctr + 1'b1;
   assign dbg_state_o  = state;

   always_comb begin
      first_low = '0;
      for (int i = NUM_CS - 1; i >= 0; i--) begin
         if (!csn_s[i]) first_low = CS_W'(i);
      end
   end

   always_comb begin
      phase_len = '0;
      case (state)
         S_CMD:   phase_len = cmd_len_q;
         S_ADDR:  phase_len = addr_len_q;
         S_DUMMY: phase_len = dummy_len_q;
         S_DATA:  phase_len = data_len_q;
         default: phase_len = '0;
      endcase
   end

   // Synchronisers; csn idles high so its flops reset high to avoid a false fall.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sck_sync  <= '0;
         sck_d     <= 1'b0;
         csn_sync1 <= '1;
         csn_s     <= '1;
         csn_d     <= '1;
         mosi_sync <= '0;
      end else begin
         sck_sync  <= {sck_sync[0], spi_sck_i};
         sck_d     <= sck_sync[1];
         csn_sync1 <= spi_csn_i;
         csn_s     <= csn_sync1;
         csn_d     <= csn_s;
         mosi_sync <= {mosi_sync[0], spi_mosi_i};
      end
   end

`ifdef SPI_COLLECTOR_MISO_EN
   always_ff @(posedge clk_i) begin
      if (rst_i) miso_sync <= '0;
      else       miso_sync <= {miso_sync[0], spi_miso_i};
   end
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state           <= S_IDLE;
         armed           <= 1'b0;
         settle          <= '0;
         cs_sel          <= '0;
         cmd_len_q       <= '0;
         addr_len_q      <= '0;
         dummy_len_q     <= '0;
         data_len_q      <= '0;
         ctr             <= '0;
         bit_cnt         <= '0;
         excess          <= 1'b0;
         cmd_sr          <= '0;
         addr_sr         <= '0;
         dummy_sr        <= '0;
         data_sr         <= '0;
         ovf_o           <= 1'b0;
         pkt.pkt_valid_o <= 1'b0;
         pkt.pkt_cmd_o   <= '0;
         pkt.pkt_addr_o  <= '0;
         pkt.pkt_dummy_o <= '0;
         pkt.pkt_data_o  <= '0;
         pkt.pkt_cs_o    <= '0;
         pkt.pkt_bits_o  <= '0;
         pkt.pkt_flag_o  <= '0;
`ifdef SPI_COLLECTOR_MISO_EN
         rdata_sr        <= '0;
         pkt.pkt_rdata_o <= '0;
`endif
      end else begin
         ovf_o <= 1'b0;
         // settle covers the two cycles where csn_s still shows its reset value.
         if (settle != 2'd2) settle <= settle + 2'd1;
         if (pkt.pkt_valid_o && pkt.pkt_ready_i) pkt.pkt_valid_o <= 1'b0;

         case (state)
            S_IDLE: begin
               if (!armed) begin
                  if (settle == 2'd2 && (&csn_s)) armed <= 1'b1;
               end else if (csn_fall_any) begin
                  cs_sel      <= first_low;
                  cmd_len_q   <= cmd_sat;
                  addr_len_q  <= addr_sat;
                  dummy_len_q <= dummy_sat;
                  data_len_q  <= data_sat;
                  ctr         <= '0;
                  bit_cnt     <= '0;
                  excess      <= 1'b0;
                  cmd_sr      <= '0;
                  addr_sr     <= '0;
                  dummy_sr    <= '0;
                  data_sr     <= '0;
`ifdef SPI_COLLECTOR_MISO_EN
                  rdata_sr    <= '0;
`endif
                  state <= next_phase(S_IDLE, cmd_sat != '0, addr_sat != '0,
                                      dummy_sat != '0, data_sat != '0);
               end
            end
            default: begin
               if (sel_rise) begin
                  state <= S_IDLE;
                  if (pkt.pkt_valid_o && !pkt.pkt_ready_i) begin
                     ovf_o <= 1'b1;
                  end else begin
                     pkt.pkt_valid_o <= 1'b1;
                     pkt.pkt_cmd_o   <= cmd_sr;
                     pkt.pkt_addr_o  <= addr_sr;
                     pkt.pkt_dummy_o <= dummy_sr;
                     pkt.pkt_data_o  <= data_sr;
                     pkt.pkt_cs_o    <= cs_sel;
                     pkt.pkt_bits_o  <= bit_cnt;
                     pkt.pkt_flag_o  <= {excess, state != S_TAIL, state == S_TAIL};
`ifdef SPI_COLLECTOR_MISO_EN
                     pkt.pkt_rdata_o <= rdata_sr;
`endif
                  end
               end else if (sck_rise) begin
                  if (bit_cnt != 16'hFFFF) bit_cnt <= bit_cnt + 16'd1;
                  case (state)
                     S_CMD:   cmd_sr   <= {cmd_sr[CMD_W-2:0], mosi_sync[1]};
                     S_ADDR:  addr_sr  <= {addr_sr[ADDR_W-2:0], mosi_sync[1]};
                     S_DUMMY: dummy_sr <= {dummy_sr[DUMMY_W-2:0], mosi_sync[1]};
                     S_DATA: begin
                        data_sr <= {data_sr[DATA_W-2:0], mosi_sync[1]};
`ifdef SPI_COLLECTOR_MISO_EN
                        rdata_sr <= {rdata_sr[DATA_W-2:0], miso_sync[1]};
`endif
                     end
                     default: excess <= 1'b1;
                  endcase
                  if (state != S_TAIL) begin
                     if (ctr_inc == phase_len) begin
                        ctr   <= '0;
                        state <= next_phase(state, 1'b0, addr_len_q != '0,
                                            dummy_len_q != '0, data_len_q != '0);
                     end else begin
                        ctr <= ctr_inc;
                     end
                  end
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_spi_frame_collector.sv
// Directed bench for spi_frame_collector: table of frames plus overflow and reset sequences.
module tb_spi_frame_collector;
   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] cmd_len, addr_len, dummy_len, data_len;
   logic       sck, mosi, miso;
   logic [3:0] csn;
   logic       ovf;
   logic [2:0] dbg_state;
   int         checks = 0;
   int         errors = 0;
   int         ovf_cnt = 0;
   int         hs_cnt = 0;

   spi_frame_collector_if pkt_if ();

   spi_frame_collector dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .cmd_len_i   (cmd_len),
      .addr_len_i  (addr_len),
      .dummy_len_i (dummy_len),
      .data_len_i  (data_len),
      .spi_sck_i   (sck),
      .spi_csn_i   (csn),
      .spi_mosi_i  (mosi),
`ifdef SPI_COLLECTOR_MISO_EN
      .spi_miso_i  (miso),
`endif
      .pkt         (pkt_if),
      .ovf_o       (ovf),
      .dbg_state_o (dbg_state)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ovf) ovf_cnt++;
      if (pkt_if.pkt_valid_o && pkt_if.pkt_ready_i) hs_cnt++;
   end

   typedef struct {
      int           cs;
      logic [5:0]   cl, al, dl, tl;
      logic [127:0] bits;
      int           n;
      logic [31:0]  e_cmd, e_addr;
      logic [15:0]  e_dummy;
      logic [31:0]  e_data;
      logic [15:0]  e_bits;
      logic [2:0]   e_flag;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic spi_begin(input int cs);
      @(negedge clk);
      csn[cs] = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic spi_bits(input logic [127:0] b, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         mosi = b[i];
         repeat (3) @(negedge clk);
         sck = 1'b1;
         repeat (3) @(negedge clk);
         sck = 1'b0;
      end
   endtask

   task automatic spi_end(input int cs);
      repeat (3) @(negedge clk);
      csn[cs] = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   task automatic wait_valid(input string name);
      int k;
      k = 0;
      while (!pkt_if.pkt_valid_o && k < 40) begin
         @(negedge clk);
         k++;
      end
      checks++;
      if (!pkt_if.pkt_valid_o) begin
         errors++;
         $display("FAIL %s: pkt_valid_o got 0 expected 1 within 40 cycles", name);
      end
   endtask

   task automatic handshake(input string name);
      pkt_if.pkt_ready_i = 1'b1;
      @(negedge clk);
      pkt_if.pkt_ready_i = 1'b0;
      chk({name, " valid_drop"}, pkt_if.pkt_valid_o, 1'b0);
   endtask

   task automatic run_vector(input int idx, input vec_t v);
      string nm;
      nm = $sformatf("vec%0d", idx);
      cmd_len = v.cl; addr_len = v.al; dummy_len = v.dl; data_len = v.tl;
      spi_begin(v.cs);
      spi_bits(v.bits, v.n);
      spi_end(v.cs);
      wait_valid(nm);
      chk({nm, " cmd"},   pkt_if.pkt_cmd_o,   v.e_cmd);
      chk({nm, " addr"},  pkt_if.pkt_addr_o,  v.e_addr);
      chk({nm, " dummy"}, pkt_if.pkt_dummy_o, v.e_dummy);
      chk({nm, " data"},  pkt_if.pkt_data_o,  v.e_data);
      chk({nm, " cs"},    pkt_if.pkt_cs_o,    v.cs);
      chk({nm, " bits"},  pkt_if.pkt_bits_o,  v.e_bits);
      chk({nm, " flag"},  pkt_if.pkt_flag_o,  v.e_flag);
      handshake(nm);
   endtask

   initial begin
      int ovf0, hs0;
      //                cs cmd    addr   dummy  data   pin bits                   n   cmd           addr          dummy     data          bits    flag
      vecs[0] = '{0, 6'd8,  6'd24, 6'd0, 6'd32, 128'h0B123456DEADBEEF, 64, 32'h0B,       32'h123456,   16'h0,    32'hDEADBEEF, 16'd64, 3'b001};
      vecs[1] = '{0, 6'd8,  6'd24, 6'd0, 6'd32, 128'h0B123,            20, 32'h0B,       32'h123,      16'h0,    32'h0,        16'd20, 3'b010};
      vecs[2] = '{2, 6'd0,  6'd0,  6'd0, 6'd8,  128'hA5C,              12, 32'h0,        32'h0,        16'h0,    32'hA5,       16'd12, 3'b101};
      vecs[3] = '{1, 6'd4,  6'd0,  6'd4, 6'd16, 128'h96BEEF,           24, 32'h9,        32'h0,        16'h6,    32'hBEEF,     16'd24, 3'b001};
      vecs[4] = '{3, 6'd63, 6'd8,  6'd0, 6'd0,  128'hCAFEF00D5A,       40, 32'hCAFEF00D, 32'h5A,       16'h0,    32'h0,        16'd40, 3'b001};
      vecs[5] = '{0, 6'd0,  6'd0,  6'd0, 6'd0,  128'h5,                3,  32'h0,        32'h0,        16'h0,    32'h0,        16'd3,  3'b101};
      vecs[6] = '{1, 6'd8,  6'd8,  6'd8, 6'd8,  128'h0,                0,  32'h0,        32'h0,        16'h0,    32'h0,        16'd0,  3'b010};

      rst = 1'b1; csn = 4'hF; sck = 1'b0; mosi = 1'b0; miso = 1'b0;
      cmd_len = '0; addr_len = '0; dummy_len = '0; data_len = '0;
      pkt_if.pkt_ready_i = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset valid", pkt_if.pkt_valid_o, 1'b0);
      chk("reset cmd",   pkt_if.pkt_cmd_o,   32'h0);
      chk("reset data",  pkt_if.pkt_data_o,  32'h0);
      chk("reset bits",  pkt_if.pkt_bits_o,  16'h0);
      chk("reset flag",  pkt_if.pkt_flag_o,  3'b000);
      chk("reset cs",    pkt_if.pkt_cs_o,    2'd0);
      chk("reset ovf",   ovf,                1'b0);
      repeat (6) @(negedge clk);

      for (int i = 0; i < 7; i++) run_vector(i, vecs[i]);
      chk("no ovf during table", ovf_cnt, 0);

      // Two frames with ready low: second one must be dropped with one ovf pulse.
      ovf0 = ovf_cnt;
      cmd_len = 6'd8; addr_len = 6'd24; dummy_len = 6'd0; data_len = 6'd32;
      spi_begin(0); spi_bits(128'h0B123456DEADBEEF, 64); spi_end(0);
      wait_valid("ovf first");
      spi_begin(1); spi_bits(128'hAA00000011111111, 64); spi_end(1);
      repeat (4) @(negedge clk);
      chk("ovf pulses",     ovf_cnt - ovf0,       1);
      chk("ovf held valid", pkt_if.pkt_valid_o,   1'b1);
      chk("ovf held cmd",   pkt_if.pkt_cmd_o,     32'h0B);
      chk("ovf held addr",  pkt_if.pkt_addr_o,    32'h123456);
      chk("ovf held data",  pkt_if.pkt_data_o,    32'hDEADBEEF);
      chk("ovf held cs",    pkt_if.pkt_cs_o,      2'd0);
      hs0 = hs_cnt;
      handshake("ovf");
      repeat (3) @(negedge clk);
      chk("ovf one handshake", hs_cnt - hs0, 1);

      // Reset in the middle of the address phase with csn still low.
      ovf0 = ovf_cnt;
      spi_begin(0);
      spi_bits(128'h0B12, 16);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      spi_bits(128'h3456DEADBEEF, 48);
      spi_end(0);
      repeat (10) @(negedge clk);
      chk("rst mid no packet", pkt_if.pkt_valid_o, 1'b0);
      chk("rst mid no ovf",    ovf_cnt - ovf0,     0);
      run_vector(7, vecs[0]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached, got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
